// File: rtl/demux_1to2_if.sv
// Valid/ready stream with packet framing, shared by the demux input and both outputs.
// The master drives data/valid/last; the slave answers with ready.
interface demux_1to2_if #(
   parameter int unsigned W = 8
);
   logic [W-1:0] data;
   logic         valid;
   logic         last;
   logic         ready;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/demux_1to2.sv
// Packet-aware 1-to-2 stream demultiplexer with a one-beat register per output.
// The route is taken from s on a packet's first beat and held until its last beat.
module demux_1to2 #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s,
   demux_1to2_if.slave  d,
   demux_1to2_if.master z0,
   demux_1to2_if.master z1,
   output logic [7:0]   cnt0,
   output logic [7:0]   cnt1,
   output logic         busy
);

   localparam logic StIdle = 1'b0;
   localparam logic StPkt  = 1'b1;

   logic         state_q, state_d;
   logic         sel_q, sel_d;
   logic         route;
   logic         accept;
   logic         load0, load1;
   logic         drain0, drain1;

   logic [W-1:0] z0_data_q, z0_data_d;
   logic         z0_valid_q, z0_valid_d;
   logic         z0_last_q, z0_last_d;
   logic [W-1:0] z1_data_q, z1_data_d;
   logic         z1_valid_q, z1_valid_d;
   logic         z1_last_q, z1_last_d;
   logic [7:0]   cnt0_q, cnt0_d;
   logic [7:0]   cnt1_q, cnt1_d;

   // Ready looks only at the routed output so a stalled sibling never blocks us.
   assign route   = (state_q == StPkt) ? sel_q : s;
   assign d.ready = route ? (!z1_valid_q || z1.ready) : (!z0_valid_q || z0.ready);
   assign accept  = d.valid && d.ready;
   assign load0   = accept && !route;
   assign load1   = accept && route;
   assign drain0  = z0_valid_q && z0.ready;
   assign drain1  = z1_valid_q && z1.ready;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      if (accept) begin
         if (state_q == StIdle) begin
            if (!d.last) begin
               state_d = StPkt;
               sel_d   = s;
            end
         end else if (d.last) begin
            state_d = StIdle;
         end
      end
   end

   always_comb begin
      z0_data_d  = z0_data_q;
      z0_last_d  = z0_last_q;
      z0_valid_d = z0_valid_q;
      if (drain0) begin
         z0_valid_d = 1'b0;
      end
      if (load0) begin
         z0_data_d  = d.data;
         z0_last_d  = d.last;
         z0_valid_d = 1'b1;
      end
   end

   always_comb begin
      z1_data_d  = z1_data_q;
      z1_last_d  = z1_last_q;
      z1_valid_d = z1_valid_q;
      if (drain1) begin
         z1_valid_d = 1'b0;
      end
      if (load1) begin
         z1_data_d  = d.data;
         z1_last_d  = d.last;
         z1_valid_d = 1'b1;
      end
   end

   // Packets are counted as their final beat leaves, wrapping naturally at 8 bits.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (drain0 && z0_last_q) begin
         cnt0_d = cnt0_q + 8'd1;
      end
      if (drain1 && z1_last_q) begin
         cnt1_d = cnt1_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         sel_q      <= 1'b0;
         z0_data_q  <= '0;
         z0_valid_q <= 1'b0;
         z0_last_q  <= 1'b0;
         z1_data_q  <= '0;
         z1_valid_q <= 1'b0;
         z1_last_q  <= 1'b0;
         cnt0_q     <= 8'd0;
         cnt1_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         z0_data_q  <= z0_data_d;
         z0_valid_q <= z0_valid_d;
         z0_last_q  <= z0_last_d;
         z1_data_q  <= z1_data_d;
         z1_valid_q <= z1_valid_d;
         z1_last_q  <= z1_last_d;
         cnt0_q     <= cnt0_d;
         cnt1_q     <= cnt1_d;
      end
   end

   assign z0.data  = z0_data_q;
   assign z0.valid = z0_valid_q;
   assign z0.last  = z0_last_q;
   assign z1.data  = z1_data_q;
   assign z1.valid = z1_valid_q;
   assign z1.last  = z1_last_q;
   assign cnt0     = cnt0_q;
   assign cnt1     = cnt1_q;
   assign busy     = (state_q == StPkt);

endmodule

// File: tb/tb_demux_1to2.sv
// Bench for demux_1to2: directed scenarios plus random traffic, all compared every cycle
// against a queue-based model of the two destinations and the open-packet route.
module tb_demux_1to2;
   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s   = 1'b0;
   logic [7:0] cnt0, cnt1;
   logic       busy;

   demux_1to2_if #(.W(W)) d_if ();
   demux_1to2_if #(.W(W)) z0_if ();
   demux_1to2_if #(.W(W)) z1_if ();

   demux_1to2 #(.W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .s    (s),
      .d    (d_if),
      .z0   (z0_if),
      .z1   (z1_if),
      .cnt0 (cnt0),
      .cnt1 (cnt1),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: each destination holds at most one beat {last, data}; open_route is -1 between packets.
   logic [W:0] q0[$];
   logic [W:0] q1[$];
   int         open_route = -1;
   int         c0 = 0;
   int         c1 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic sv, input logic [7:0] dv, input logic v, input logic l,
                        input logic r0, input logic r1);
      s           = sv;
      d_if.data   = dv;
      d_if.valid  = v;
      d_if.last   = l;
      z0_if.ready = r0;
      z1_if.ready = r1;
   endtask

   task automatic compare_outputs();
      chk("z0_valid", 32'(z0_if.valid), 32'(q0.size() != 0));
      chk("z1_valid", 32'(z1_if.valid), 32'(q1.size() != 0));
      if (q0.size() != 0) begin
         chk("z0_data", 32'(z0_if.data), 32'(q0[0][W-1:0]));
         chk("z0_last", 32'(z0_if.last), 32'(q0[0][W]));
      end
      if (q1.size() != 0) begin
         chk("z1_data", 32'(z1_if.data), 32'(q1[0][W-1:0]));
         chk("z1_last", 32'(z1_if.last), 32'(q1[0][W]));
      end
      chk("cnt0", 32'(cnt0), 32'(c0));
      chk("cnt1", 32'(cnt1), 32'(c1));
      chk("busy", 32'(busy), 32'(open_route >= 0));
   endtask

   // Called just after an edge with new inputs applied; returns just after the next edge.
   task automatic step();
      int   r;
      logic exp_ready, acc, dr0, dr1;
      #1;
      r         = (open_route >= 0) ? open_route : int'(s);
      exp_ready = (r == 0) ? (q0.size() == 0 || z0_if.ready) : (q1.size() == 0 || z1_if.ready);
      chk("d_ready", 32'(d_if.ready), 32'(exp_ready));
      acc = d_if.valid && exp_ready;
      dr0 = (q0.size() != 0) && z0_if.ready;
      dr1 = (q1.size() != 0) && z1_if.ready;
      @(posedge clk);
      #1;
      if (dr0) begin
         if (q0[0][W]) c0 = (c0 + 1) % 256;
         void'(q0.pop_front());
      end
      if (dr1) begin
         if (q1[0][W]) c1 = (c1 + 1) % 256;
         void'(q1.pop_front());
      end
      if (acc) begin
         if (r == 0) q0.push_back({d_if.last, d_if.data});
         else        q1.push_back({d_if.last, d_if.data});
         open_route = d_if.last ? -1 : r;
      end
      compare_outputs();
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      open_route = -1;
      c0 = 0;
      c1 = 0;
   endtask

   // Asserts reset between edges and checks its effect before any clock edge arrives.
   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      compare_outputs();
      chk("rst_z0_data", 32'(z0_if.data), 32'h0);
      chk("rst_z1_data", 32'(z1_if.data), 32'h0);
      @(posedge clk);
      #3 rst = 1'b0;
   endtask

   initial begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      async_reset();

      // Single beat to z1
      drive(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      chk("sb_z1_data", 32'(z1_if.data), 32'hA5);
      chk("sb_z1_valid", 32'(z1_if.valid), 32'h1);
      chk("sb_z1_last", 32'(z1_if.last), 32'h1);
      chk("sb_z0_valid", 32'(z0_if.valid), 32'h0);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      chk("sb_cnt1", 32'(cnt1), 32'h1);
      chk("sb_busy", 32'(busy), 32'h0);

      // Route lock: s toggles after the first beat
      drive(1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      chk("rl_busy", 32'(busy), 32'h1);
      drive(1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      chk("rl_z0_b2", 32'(z0_if.data), 32'h02);
      drive(1'b0, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      chk("rl_z0_b3", 32'(z0_if.data), 32'h03);
      chk("rl_z1_valid", 32'(z1_if.valid), 32'h0);
      drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      chk("rl_cnt0", 32'(cnt0), 32'h1);

      // Backpressure on z0
      drive(1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      drive(1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1);
      #1 chk("bp_ready_low", 32'(d_if.ready), 32'h0);
      step();
      chk("bp_z0_hold", 32'(z0_if.data), 32'h11);
      drive(1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1);
      #1 chk("bp_ready_high", 32'(d_if.ready), 32'h1);
      step();
      chk("bp_z0_new", 32'(z0_if.data), 32'h22);
      chk("bp_z0_valid", 32'(z0_if.valid), 32'h1);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step();

      // Independence: z1 stalled while z0 streams
      drive(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 8'(8'h40 + i), 1'b1, 1'(i == 2), 1'b1, 1'b0);
         step();
         chk("ind_z0_stream", 32'(z0_if.data), 32'(8'h40 + i));
      end
      chk("ind_z1_hold", 32'(z1_if.data), 32'h33);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step();

      // Reset in the middle of a 4-beat packet
      drive(1'b0, 8'h50, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      drive(1'b0, 8'h51, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      chk("mid_busy", 32'(busy), 32'h1);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      async_reset();
      chk("mid_rst_busy", 32'(busy), 32'h0);
      drive(1'b1, 8'h60, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      chk("mid_z1_valid", 32'(z1_if.valid), 32'h1);
      chk("mid_z1_data", 32'(z1_if.data), 32'h60);
      chk("mid_z0_valid", 32'(z0_if.valid), 32'h0);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step();

      // Counter wrap
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      async_reset();
      for (int i = 0; i < 256; i++) begin
         drive(1'b0, 8'(i), 1'b1, 1'b1, 1'b1, 1'b1);
         step();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      #1 chk("wrap_255", 32'(cnt0), 32'd255);
      step();
      chk("wrap_0", 32'(cnt0), 32'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) < 7),
               1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 6),
               1'($urandom_range(0, 9) < 6));
         step();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
